// File: rtl/fir_decim_accum.sv
// Integrate-and-dump decimator for the FIR output stream.
// Sums DECIM consecutive signed samples and emits one widened sum per group;
// an input tlast dumps the group early and marks it partial via tuser.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   s_axis_dec_*          AXI-Stream slave (tdata/tvalid/tlast in, tready out)
//   m_axis_dec_*          AXI-Stream master (tdata/tvalid/tlast/tuser out, tready in)
module fir_decim_accum #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned DECIM     = 4,
    parameter int unsigned OUT_WIDTH = IN_WIDTH + $clog2(DECIM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  s_axis_dec_tdata,
    input  logic                 s_axis_dec_tvalid,
    input  logic                 s_axis_dec_tlast,
    output logic                 s_axis_dec_tready,
    output logic [OUT_WIDTH-1:0] m_axis_dec_tdata,
    output logic                 m_axis_dec_tvalid,
    output logic                 m_axis_dec_tlast,
    output logic                 m_axis_dec_tuser,
    input  logic                 m_axis_dec_tready
);

    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    // HOLD means an output beat is pending; the state register is the output valid.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   last_q, last_d;
    logic                   user_q, user_d;

    logic                   accept;
    logic                   group_full;
    logic signed [OUT_WIDTH-1:0] sext;
    logic signed [OUT_WIDTH-1:0] sum;

    // Input may advance whenever the output slot is empty or draining this cycle.
    assign s_axis_dec_tready = reset && ((state_q != HOLD) || m_axis_dec_tready);
    assign accept            = s_axis_dec_tvalid && s_axis_dec_tready;
    assign group_full        = (cnt_q == CNT_W'(DECIM - 1));
    assign sext              = OUT_WIDTH'($signed(s_axis_dec_tdata));
    assign sum               = acc_q + sext;

    // State, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

    // Next-state: drain pending output, then accumulate or dump the accepted beat.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;
        user_d  = user_q;

        if ((state_q == HOLD) && m_axis_dec_tready) begin
            state_d = ACCUM;
        end

        if (accept) begin
            if (group_full || s_axis_dec_tlast) begin
                state_d = HOLD;
                data_d  = sum;
                last_d  = s_axis_dec_tlast;
                user_d  = !group_full;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d   = sum;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    assign m_axis_dec_tvalid = (state_q == HOLD);
    assign m_axis_dec_tdata  = data_q;
    assign m_axis_dec_tlast  = last_q;
    assign m_axis_dec_tuser  = user_q;

endmodule

// File: tb/tb_fir_decim_accum.sv
// Directed bench for fir_decim_accum (defaults IN_WIDTH=16, DECIM=4).
module tb_fir_decim_accum;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 18;

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic             s_tready;
    logic [OUT_W-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tuser;
    logic             m_tready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int d;
        bit l;
        bit u;
    } exp_t;

    exp_t exp_q[$];
    int   xin[202];
    int   samp[200];

    fir_decim_accum dut (
        .clk              (clk),
        .reset            (reset),
        .s_axis_dec_tdata (s_tdata),
        .s_axis_dec_tvalid(s_tvalid),
        .s_axis_dec_tlast (s_tlast),
        .s_axis_dec_tready(s_tready),
        .m_axis_dec_tdata (m_tdata),
        .m_axis_dec_tvalid(m_tvalid),
        .m_axis_dec_tlast (m_tlast),
        .m_axis_dec_tuser (m_tuser),
        .m_axis_dec_tready(m_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] sdata();
        return 32'($signed(m_tdata));
    endfunction

    // Present one beat from posedge+1 and hold it until accepted.
    task automatic send(input int d, input bit l);
        int n = 0;
        s_tdata  = IN_W'(d);
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 'x;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk(tag, 32'(m_tvalid), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int d, input bit l, input bit u);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(m_tvalid), 1);
        chk({tag, "_data"}, sdata(), d);
        chk({tag, "_last"}, 32'(m_tlast), 32'(l));
        chk({tag, "_user"}, 32'(m_tuser), 32'(u));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 'x;
        m_tready = 1'b1;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(m_tvalid), 0);
        chk("rst_data", sdata(), 0);
        chk("rst_last", 32'(m_tlast), 0);
        chk("rst_user", 32'(m_tuser), 0);
        chk("rst_sready", 32'(s_tready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic group 1+2+3+4.
        send(1, 0); idle_chk("g1_idle1");
        send(2, 0); idle_chk("g1_idle2");
        send(3, 0); idle_chk("g1_idle3");
        send(4, 0);
        expect_out("g1", 10, 0, 0);
        idle_chk("g1_after");

        // Signed extremes.
        repeat (4) send(-32768, 0);
        @(negedge clk);
        chk("neg_bits", 32'(m_tdata), 32'h20000);
        @(posedge clk);
        #1;
        idle_chk("neg_after");
        repeat (4) send(32767, 0);
        expect_out("pos", 131068, 0, 0);

        // Early tlast then a full group with a cleared accumulator.
        send(5, 0);
        send(7, 1);
        expect_out("early", 12, 1, 1);
        repeat (4) send(1, 0);
        expect_out("after_early", 4, 0, 0);

        // Backpressure: output held, no input consumed while stalled.
        m_tready = 1'b0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        s_tdata  = IN_W'(100);
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(m_tvalid), 1);
            chk("bp_data", sdata(), 10);
            chk("bp_lastuser", 32'({m_tlast, m_tuser}), 0);
            chk("bp_sready", 32'(s_tready), 0);
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        @(negedge clk);
        chk("bp_release_sready", 32'(s_tready), 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = 'x;
        idle_chk("bp_drained");
        send(1, 0); send(1, 0); send(1, 0);
        expect_out("bp_resume", 103, 0, 0);

        // Mid-group reset discards the partial sum.
        send(9, 0); send(9, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_chk("mid_rst_idle");
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        expect_out("mid_rst", 10, 0, 0);

        // Stream from a 1-2-1 FIR model with random gaps on both sides.
        for (int i = 0; i < 202; i++) xin[i] = int'($urandom_range(0, 16000)) - 8000;
        for (int i = 0; i < 200; i++) samp[i] = xin[i + 2] + 2 * xin[i + 1] + xin[i];
        begin
            int acc = 0;
            int c = 0;
            for (int i = 0; i < 200; i++) begin
                bit l;
                l = (i % 10 == 9);
                acc += samp[i];
                c++;
                if (c == 4 || l) begin
                    exp_t e;
                    e.d = acc; e.l = l; e.u = (c != 4);
                    exp_q.push_back(e);
                    acc = 0;
                    c = 0;
                end
            end
        end
        chk("model_groups", exp_q.size(), 60);
        begin
            int  in_idx = 0;
            int  out_cnt = 0;
            int  cyc = 0;
            bit  took = 1'b1;
            while ((out_cnt < 60) && (cyc < 5000)) begin
                if (!s_tvalid || took) begin
                    if ((in_idx < 200) && ($urandom_range(0, 3) != 0)) begin
                        s_tvalid = 1'b1;
                        s_tdata  = IN_W'(samp[in_idx]);
                        s_tlast  = (in_idx % 10 == 9);
                    end else begin
                        s_tvalid = 1'b0;
                        s_tlast  = 1'b0;
                        s_tdata  = 'x;
                    end
                end
                m_tready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (m_tvalid && m_tready) begin
                    exp_t e;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("strm_data", sdata(), e.d);
                        chk("strm_last", 32'(m_tlast), 32'(e.l));
                        chk("strm_user", 32'(m_tuser), 32'(e.u));
                    end else begin
                        chk("strm_extra_beat", 1, 0);
                    end
                    out_cnt++;
                end
                took = s_tvalid && s_tready;
                if (took) in_idx++;
                @(posedge clk);
                #1;
                cyc++;
            end
            s_tvalid = 1'b0;
            s_tdata  = 'x;
            chk("strm_outputs", out_cnt, 60);
            chk("strm_inputs", in_idx, 200);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_decim_accum.md
Name: fir_decim_accum

Overview:
- Integrate-and-dump decimator placed directly downstream of the FIR filter.
- Consumes the FIR's AXI-Stream master output (m_axis_fir_*) on its slave port.
- Sums DECIM consecutive signed samples and emits one widened sum per group on its own AXI-Stream master port.
- Packet boundaries (tlast) force an early dump, so frames never merge across groups.

Parameters:
- IN_WIDTH, 16: width of signed input samples (matches FIR output data width).
- DECIM, 4: decimation factor, samples per output; legal range 1..256.
- OUT_WIDTH, IN_WIDTH+$clog2(DECIM): output sum width (18 at defaults); derived, must not be overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; 0 = in reset.
- s_axis_dec_tdata  in  IN_WIDTH  signed input sample from FIR.
- s_axis_dec_tvalid  in  1  input beat valid.
- s_axis_dec_tlast  in  1  last sample of packet.
- s_axis_dec_tready  out  1  block can accept an input beat.
- m_axis_dec_tdata  out  OUT_WIDTH  signed accumulated sum.
- m_axis_dec_tvalid  out  1  output beat valid.
- m_axis_dec_tlast  out  1  output closes a packet.
- m_axis_dec_tuser  out  1  1 = partial group (dumped early by tlast with fewer than DECIM samples).
- m_axis_dec_tready  in  1  downstream accepts output.

Behaviour:
- Reset (reset==0 at a clk edge):
  - acc=0, cnt=0, state=ACCUM.
  - m_axis_dec_tvalid=0, m_axis_dec_tdata=0, m_axis_dec_tlast=0, m_axis_dec_tuser=0.
  - Mid-operation reset discards the partial sum and any pending output; no beat is emitted.
- Ready rule: s_axis_dec_tready = reset && (!m_axis_dec_tvalid || m_axis_dec_tready).
  - Combinational from the registered valid and the downstream ready.
  - Low during reset.
- An input beat is accepted when s_tvalid && s_tready. Only accepted beats change acc or cnt.
- Arithmetic:
  - Sample is sign-extended to OUT_WIDTH before addition.
  - sum = acc + sext(sample).
  - No saturation; OUT_WIDTH guarantees no overflow for DECIM samples.
- Dump condition on an accepted beat: (cnt == DECIM-1) || s_axis_dec_tlast.
  - Dump:
    - Register m_tdata=sum, m_tvalid=1, m_tlast=s_tlast, m_tuser=(cnt != DECIM-1).
    - acc=0, cnt=0.
  - No dump: acc=sum, cnt=cnt+1.
- Latency: output is valid on the cycle after the dump-triggering beat is accepted.
- Output handshake:
  - m_tdata/tlast/tuser stay stable while m_tvalid && !m_tready.
  - m_tvalid clears after a transfer unless a new dump loads the same cycle. Back-to-back dumps sustain 1 output/cycle at DECIM=1.
- Simultaneous events:
  - An output transfer and an input dump in the same cycle load the new result with no bubble.
  - Output stalled: s_tready=0, so the input stalls and acc/cnt hold.
- FSM: ACCUM (cnt<DECIM-1, accumulating) and HOLD (output pending).
  - HOLD is informational only; the ready rule above is normative.
  - HOLD with m_tready returns to ACCUM.
- DECIM=1: every beat dumps; m_tuser always 0; output = sign-extended input.
- Wrap-around: cnt never exceeds DECIM-1. acc returns to 0 after every dump, with no carry-over between groups.
- tvalid must not depend on tready. Upstream X on tdata while tvalid=0 must not corrupt acc.

Test Plan:
- Reset low 2 cycles, then high; feed 1,2,3,4 (no tlast), m_tready=1 -> one beat: tdata=10, tlast=0, tuser=0, one cycle after the 4th accept; tvalid low otherwise.
- Signed: feed -32768,-32768,-32768,-32768 -> tdata=-131072 (18'h20000), no overflow; then 32767 x4 -> 131068.
- Early tlast: feed 5,7 with tlast on 7 -> tdata=12, tlast=1, tuser=1; next group 1,1,1,1 -> 4, tuser=0 (acc cleared).
- Backpressure: hold m_tready=0 for 5 cycles after a dump -> tdata/tlast/tuser stable, s_tready=0, no input consumed; release -> transfer, then accumulation resumes with the correct next sum.
- Reset mid-group: feed 9,9, assert reset one cycle, feed 1,2,3,4 -> single output 10; no output containing 18.
- Stream from FIR model, random tvalid/tready gaps, 200 samples with tlast every 10 -> outputs match reference model sums; 2 full + 1 partial (size 2) per packet; tlast only on partials.
